// File: rtl/filter_mem.sv
// Filter-row register file for one PE: paired write-address/write-data streams
// commit one word, and a read-address stream returns one read-data token.
module filter_mem #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_F = 3,
  parameter int unsigned ADDR_F  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              waddr_valid,
  input  logic [ADDR_F-1:0] waddr,
  output logic              waddr_ready,
  input  logic              wdata_valid,
  input  logic [WIDTH-1:0]  wdata,
  output logic              wdata_ready,
  input  logic              raddr_valid,
  input  logic [ADDR_F-1:0] raddr,
  output logic              raddr_ready,
  output logic              rdata_valid,
  output logic [WIDTH-1:0]  rdata,
  input  logic              rdata_ready
);

  typedef enum logic {R_IDLE, R_OUT} rstate_t;

  logic [WIDTH-1:0]  mem [DEPTH_F];
  logic              addr_full;
  logic              data_full;
  logic [ADDR_F-1:0] addr_reg;
  logic [WIDTH-1:0]  data_reg;
  logic              commit;
  logic [WIDTH-1:0]  rd_word;
  rstate_t           state_q;
  rstate_t           state_d;

  assign commit      = addr_full & data_full;
  assign waddr_ready = ~addr_full;
  assign wdata_ready = ~data_full;

  // Both holding registers full blocks new captures; the commit edge frees both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_full <= 1'b0;
      data_full <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (commit) begin
      addr_full <= 1'b0;
      data_full <= 1'b0;
    end else begin
      if (waddr_valid && !addr_full) begin
        addr_reg  <= waddr;
        addr_full <= 1'b1;
      end
      if (wdata_valid && !data_full) begin
        data_reg  <= wdata;
        data_full <= 1'b1;
      end
    end
  end

  // Out-of-range addresses match no entry, so such writes are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_F; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned i = 0; i < DEPTH_F; i++) begin
        if (addr_reg == ADDR_F'(i)) begin
          mem[i] <= data_reg;
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH_F; i++) begin
      if (raddr == ADDR_F'(i)) begin
        rd_word = mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sampled from the pre-edge array, so a same-edge write yields the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (state_q == R_IDLE && raddr_valid) begin
      rdata <= rd_word;
    end
  end

  always_comb begin
    state_d     = state_q;
    raddr_ready = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      R_IDLE: begin
        raddr_ready = 1'b1;
        if (raddr_valid) state_d = R_OUT;
      end
      R_OUT: begin
        rdata_valid = 1'b1;
        if (rdata_ready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_filter_mem.sv
// Self-checking bench for filter_mem: directed plan items plus randomized
// writes/reads compared against a plain-array model of the filter row.
module tb_filter_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       waddr_valid;
  logic [1:0] waddr;
  logic       waddr_ready;
  logic       wdata_valid;
  logic [7:0] wdata;
  logic       wdata_ready;
  logic       raddr_valid;
  logic [1:0] raddr;
  logic       raddr_ready;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       rdata_ready;

  int total = 0;
  int bad   = 0;
  logic [7:0] model [4];

  filter_mem #(.WIDTH(8), .DEPTH_F(3), .ADDR_F(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .waddr_valid(waddr_valid), .waddr(waddr), .waddr_ready(waddr_ready),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .raddr_valid(raddr_valid), .raddr(raddr), .raddr_ready(raddr_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_ready(rdata_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expect_word(input logic [1:0] a);
    return (a < 2'd3) ? model[a] : 8'h00;
  endfunction

  // order: 0 = address first, 1 = data first, 2 = same cycle; gap = idle cycles between.
  task automatic write_word(input logic [1:0] a, input logic [7:0] d, input int order, input int gap);
    @(negedge clk);
    check("waddr_ready idle", waddr_ready, 1);
    check("wdata_ready idle", wdata_ready, 1);
    if (order == 2) begin
      waddr_valid = 1'b1; waddr = a;
      wdata_valid = 1'b1; wdata = d;
      @(posedge clk); #1;
      waddr_valid = 1'b0; wdata_valid = 1'b0;
    end else begin
      if (order == 0) begin waddr_valid = 1'b1; waddr = a; end
      else            begin wdata_valid = 1'b1; wdata = d; end
      @(posedge clk); #1;
      waddr_valid = 1'b0; wdata_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("first stream stalled", (order == 0) ? waddr_ready : wdata_ready, 0);
        check("second stream open",  (order == 0) ? wdata_ready : waddr_ready, 1);
      end
      @(negedge clk);
      if (order == 0) begin wdata_valid = 1'b1; wdata = d; end
      else            begin waddr_valid = 1'b1; waddr = a; end
      @(posedge clk); #1;
      waddr_valid = 1'b0; wdata_valid = 1'b0;
    end
    check("waddr_ready paired", waddr_ready, 0);
    check("wdata_ready paired", wdata_ready, 0);
    @(posedge clk); #1;
    check("waddr_ready after commit", waddr_ready, 1);
    check("wdata_ready after commit", wdata_ready, 1);
    if (a < 2'd3) model[a] = d;
  endtask

  task automatic read_check(input logic [1:0] a, input int hold);
    logic [7:0] exp;
    exp = expect_word(a);
    @(negedge clk);
    check("raddr_ready idle", raddr_ready, 1);
    check("rdata_valid idle", rdata_valid, 0);
    raddr_valid = 1'b1; raddr = a;
    @(posedge clk); #1;
    raddr_valid = 1'b0;
    check("rdata_valid latency", rdata_valid, 1);
    check("rdata value", rdata, exp);
    check("raddr_ready busy", raddr_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold rdata_valid", rdata_valid, 1);
      check("hold rdata stable", rdata, exp);
      check("hold raddr_ready", raddr_ready, 0);
    end
    @(negedge clk);
    rdata_ready = 1'b1;
    @(posedge clk); #1;
    rdata_ready = 1'b0;
    check("raddr_ready after consume", raddr_ready, 1);
    check("rdata_valid after consume", rdata_valid, 0);
  endtask

  // Read lookup lands on the same edge as the write commit; the old word is expected.
  task automatic collide(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] old_word;
    old_word = expect_word(a);
    @(negedge clk);
    waddr_valid = 1'b1; waddr = a;
    wdata_valid = 1'b1; wdata = d;
    @(posedge clk); #1;
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    @(negedge clk);
    raddr_valid = 1'b1; raddr = a;
    @(posedge clk); #1;
    raddr_valid = 1'b0;
    check("collision old value", rdata, old_word);
    check("collision write freed", waddr_ready, 1);
    if (a < 2'd3) model[a] = d;
    @(negedge clk);
    rdata_ready = 1'b1;
    @(posedge clk); #1;
    rdata_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    waddr_valid = 1'b0; waddr = '0;
    wdata_valid = 1'b0; wdata = '0;
    raddr_valid = 1'b0; raddr = '0;
    rdata_ready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    #12;
    check("reset waddr_ready", waddr_ready, 1);
    check("reset wdata_ready", wdata_ready, 1);
    check("reset raddr_ready", raddr_ready, 1);
    check("reset rdata_valid", rdata_valid, 0);
    check("reset rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) read_check(2'(i), 0);
    for (int i = 0; i < 3; i++) write_word(2'(i), 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) read_check(2'(i), 0);

    write_word(2'd1, 8'hA5, 1, 3);
    read_check(2'd1, 0);
    write_word(2'd2, 8'h3C, 2, 0);
    read_check(2'd2, 0);
    read_check(2'd0, 5);

    write_word(2'd3, 8'hFF, 0, 1);
    for (int i = 0; i < 4; i++) read_check(2'(i), 0);

    collide(2'd0, 8'h5A);
    read_check(2'd0, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: write_word(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)));
        2:    read_check(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        default: collide(2'($urandom_range(0, 2)), 8'($urandom));
      endcase
    end
    for (int i = 0; i < 3; i++) read_check(2'(i), 0);

    // Reset with a pending address token and an outstanding read-data token.
    write_word(2'd1, 8'h77, 2, 0);
    @(negedge clk);
    waddr_valid = 1'b1; waddr = 2'd1;
    raddr_valid = 1'b1; raddr = 2'd1;
    @(posedge clk); #1;
    waddr_valid = 1'b0; raddr_valid = 1'b0;
    check("pre-reset addr held", waddr_ready, 0);
    check("pre-reset rdata_valid", rdata_valid, 1);
    check("pre-reset rdata", rdata, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset waddr_ready", waddr_ready, 1);
    check("async reset wdata_ready", wdata_ready, 1);
    check("async reset raddr_ready", raddr_ready, 1);
    check("async reset rdata_valid", rdata_valid, 0);
    check("async reset rdata", rdata, 0);
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) read_check(2'(i), 0);
    write_word(2'd2, 8'hC3, 1, 0);
    read_check(2'd2, 1);
    read_check(2'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
